bcd_timer_ctrl: RTL and testbench

//   N-digit BCD countdown/count-up timer with a per-digit radix pattern (e.g. m:ss.t).

---
 rtl/bcd_timer_ctrl_if.sv | 23 ++
 rtl/bcd_timer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_ctrl_if.sv
// Front-end/pin bundle of the BCD timer: control pulses in, multiplexed display and status out.
interface bcd_timer_ctrl_if #(
  parameter int NDIG = 4
);
  logic            en;
  logic            enter_p;
  logic            inc_p;
  logic            dir_p;
  logic [NDIG-1:0] DIGIT;
  logic [6:0]      DISPLAY;
  logic            led_dir;
  logic            done;

  modport master (
    output en, enter_p, inc_p, dir_p,
    input  DIGIT, DISPLAY, led_dir, done
  );

  modport slave (
    input  en, enter_p, inc_p, dir_p,
    output DIGIT, DISPLAY, led_dir, done
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// N-digit BCD up/down timer with per-digit radix and multiplexed seven-segment output.
// Optional BCD_TIMER_BLINK_EN: blank the digit being edited in NUM_SET at ~6 Hz.
module bcd_timer_ctrl #(
  parameter int              NDIG        = 4,
  parameter logic [NDIG-1:0] RADIX6_MASK = NDIG'(4'b0100),
  parameter int              TOP_MAX     = 1,
  parameter int              TICK_DIV    = 10_000_000,
  parameter int              SCAN_BITS   = 16
) (
  input  logic             clk,
  input  logic             pulse_rst,
  bcd_timer_ctrl_if.slave  bus
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] EDIT_TOP  = IDX_W'(NDIG - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {DIR_SET, NUM_SET, RUN} state_t;
  typedef logic [NDIG-1:0][3:0] digs_t;

  state_t            state, state_nxt;
  logic              dir;
  digs_t             target, value;
  logic [IDX_W-1:0]  edit_idx, scan_idx;
  logic [DIV_W-1:0]  div;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic              tick, run_cnt, done_nxt, blank_edit;
  logic [6:0]        seg_nxt;

  // Largest value a digit reaches while counting.
  function automatic logic [3:0] radix_max(input int i);
    return RADIX6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  // Largest value a digit may be set to; the top digit is further limited.
  function automatic logic [3:0] set_max(input int i);
    return (i == NDIG - 1) ? 4'(TOP_MAX) : radix_max(i);
  endfunction

  function automatic digs_t bcd_up(input digs_t v);
    digs_t r;
    logic  carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[i] >= radix_max(i)) r[i] = 4'd0;
        else begin
          r[i]  = v[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic digs_t bcd_down(input digs_t v);
    digs_t r;
    logic  borrow;
    r = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) r[i] = radix_max(i);
        else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

`ifdef BCD_TIMER_BLINK_EN
  logic [23:0] blink_cnt;
  always_ff @(posedge clk or posedge pulse_rst) begin
    if (pulse_rst) blink_cnt <= '0;
    else           blink_cnt <= blink_cnt + 24'd1;
  end
  assign blank_edit = blink_cnt[23];
`else
  assign blank_edit = 1'b0;
`endif

  always_ff @(posedge clk or posedge pulse_rst) begin
    if (pulse_rst) state <= DIR_SET;
    else           state <= state_nxt;
  end

  // RUN has no exit except reset.
  always_comb begin
    state_nxt = state;
    case (state)
      DIR_SET: if (bus.enter_p) state_nxt = NUM_SET;
      NUM_SET: if (bus.enter_p && edit_idx == '0) state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    run_cnt  = (state == RUN) && bus.en;
    tick     = run_cnt && (div == DIV_W'(TICK_DIV - 1));
    done_nxt = (state == RUN) && (dir ? (value == '0) : (value == target));
    seg_nxt  = SEG_DASH;
    case (state)
      NUM_SET: begin
        if (blank_edit && scan_idx == edit_idx) seg_nxt = SEG_BLANK;
        else                                    seg_nxt = seg7(target[scan_idx]);
      end
      RUN:     seg_nxt = seg7(value[scan_idx]);
      default: seg_nxt = SEG_DASH;
    endcase
  end

  // Settings and count value; enter_p wins over inc_p.
  always_ff @(posedge clk or posedge pulse_rst) begin
    if (pulse_rst) begin
      dir      <= 1'b0;
      target   <= '0;
      value    <= '0;
      edit_idx <= EDIT_TOP;
    end else begin
      case (state)
        DIR_SET: begin
          if (bus.dir_p) dir <= ~dir;
          if (bus.enter_p) begin
            target   <= '0;
            edit_idx <= EDIT_TOP;
          end
        end
        NUM_SET: begin
          if (bus.enter_p) begin
            if (edit_idx == '0) value <= dir ? target : '0;
            else                edit_idx <= edit_idx - IDX_W'(1);
          end else if (bus.inc_p) begin
            if (target[edit_idx] >= set_max(int'(edit_idx))) target[edit_idx] <= 4'd0;
            else target[edit_idx] <= target[edit_idx] + 4'd1;
          end
        end
        RUN: begin
          if (tick) begin
            if (dir) begin
              if (value != '0) value <= bcd_down(value);
            end else if (value != target) begin
              value <= bcd_up(value);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Divider: cleared outside RUN, frozen while paused.
  always_ff @(posedge clk or posedge pulse_rst) begin
    if (pulse_rst)           div <= '0;
    else if (state != RUN)   div <= '0;
    else if (run_cnt)        div <= tick ? '0 : div + DIV_W'(1);
  end

  // Display scan; DIGIT and DISPLAY share one register stage.
  always_ff @(posedge clk or posedge pulse_rst) begin
    if (pulse_rst) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      bus.DIGIT   <= ~NDIG'(1);
      bus.DISPLAY <= SEG_DASH;
      bus.led_dir <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_BITS'(1);
      if (&scan_cnt) scan_idx <= (scan_idx == EDIT_TOP) ? '0 : scan_idx + IDX_W'(1);
      bus.DIGIT   <= ~(NDIG'(1) << scan_idx);
      bus.DISPLAY <= seg_nxt;
      bus.led_dir <= dir;
      bus.done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: digit setting, up/down counting, pause, reset and scan.
module tb_bcd_timer_ctrl;

  logic clk = 1'b0;
  logic pulse_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_v;

  always #5 clk = ~clk;

  bcd_timer_ctrl_if #(.NDIG(4)) bus ();

  bcd_timer_ctrl #(
    .NDIG(4), .TICK_DIV(4), .SCAN_BITS(2)
  ) dut (
    .clk(clk), .pulse_rst(pulse_rst), .bus(bus)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Dash/blank/unknown patterns read back as F.
  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (enc(4'(d)) == s) return 4'(d);
    return 4'hF;
  endfunction

  // Reference BCD increment for the m:ss.t radix pattern.
  function automatic logic [15:0] model_up(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    logic [3:0]  mx;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mx = (i == 2) ? 4'd5 : 4'd9;
      if (c) begin
        if (v[4*i +: 4] == mx) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic e, input logic i, input logic d);
    @(negedge clk);
    bus.enter_p = e; bus.inc_p = i; bus.dir_p = d;
    @(negedge clk);
    bus.enter_p = 1'b0; bus.inc_p = 1'b0; bus.dir_p = 1'b0;
  endtask

  task automatic tick_step();
    @(negedge clk);
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
  endtask

  // Reconstruct the 4 shown digits over more than one full scan rotation.
  task automatic read_disp(output logic [15:0] v);
    logic [3:0] sel;
    v = 16'hEEEE;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        sel = 4'b0001 << k;
        if (bus.DIGIT == ~sel) v[4*k +: 4] = dec(bus.DISPLAY);
      end
    end
  endtask

  task automatic sb_check(input string tag);
    logic [15:0] got, exp;
    read_disp(got);
    exp = exp_q.pop_front();
    check(tag, {16'h0, got}, {16'h0, exp});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 pulse_rst = 1'b1;
    repeat (2) @(negedge clk);
    pulse_rst = 1'b0;
  endtask

  initial begin
    logic       sync_ok;
    logic       dig_ok, seg_ok;
    logic [3:0] sel, dg;
    logic [15:0] shown;
    bus.en = 1'b0; bus.enter_p = 1'b0; bus.inc_p = 1'b0; bus.dir_p = 1'b0;

    #2 pulse_rst = 1'b1;
    #1;
    check("rst_digit", 32'(bus.DIGIT), 32'b1110);
    check("rst_display", 32'(bus.DISPLAY), 32'b0111111);
    check("rst_led_dir", 32'(bus.led_dir), 0);
    check("rst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    pulse_rst = 1'b0;

    exp_q.push_back(16'hFFFF); sb_check("dirset_dash");
    repeat (3) pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("led_dir_toggled", 32'(bus.led_dir), 1);
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'h0000); sb_check("numset_init");
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("dir_p_ignored", 32'(bus.led_dir), 1);

    exp_q.push_back(16'h1000); pulse(1'b0, 1'b1, 1'b0); sb_check("top_inc1");
    exp_q.push_back(16'h0000); pulse(1'b0, 1'b1, 1'b0); sb_check("top_wrap");
    exp_q.push_back(16'h1000); pulse(1'b0, 1'b1, 1'b0); sb_check("top_inc3");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back(16'h1500); sb_check("d2_five");
    exp_q.push_back(16'h1000); pulse(1'b0, 1'b1, 1'b0); sb_check("d2_wrap");
    exp_q.push_back(16'h1000); pulse(1'b1, 1'b1, 1'b0); sb_check("enter_over_inc");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // Counting down from 1:00.0
    exp_q.push_back(16'h1000); sb_check("down_start");
    check("down_done_low", 32'(bus.done), 0);
    exp_q.push_back(16'h0599); tick_step(); sb_check("down_borrow");
    exp_q.push_back(16'h0598); tick_step(); sb_check("down_step2");
    @(negedge clk);
    bus.en = 1'b1;
    repeat (598 * 4) @(negedge clk);
    bus.en = 1'b0;
    exp_q.push_back(16'h0000); sb_check("down_zero");
    check("down_done", 32'(bus.done), 1);
    repeat (3) tick_step();
    exp_q.push_back(16'h0000); sb_check("down_hold");

    @(negedge clk);
    #2 pulse_rst = 1'b1;
    #1;
    check("midrun_digit", 32'(bus.DIGIT), 32'b1110);
    check("midrun_display", 32'(bus.DISPLAY), 32'b0111111);
    check("midrun_done", 32'(bus.done), 0);
    check("midrun_led_dir", 32'(bus.led_dir), 0);
    @(negedge clk);
    pulse_rst = 1'b0;
    exp_q.push_back(16'hFFFF); sb_check("after_rst_dash");

    // Counting up to 0:01.2
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back(16'h0012); sb_check("up_target");
    pulse(1'b1, 1'b0, 1'b0);
    model_v = 16'h0000;
    exp_q.push_back(model_v); sb_check("up_start");
    check("up_done_low", 32'(bus.done), 0);
    check("up_led_dir", 32'(bus.led_dir), 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) begin
        @(negedge clk); bus.en = 1'b1;
        repeat (2) @(negedge clk); bus.en = 1'b0;
        exp_q.push_back(model_v); sb_check("pause_freeze");
        @(negedge clk); bus.en = 1'b1;
        repeat (2) @(negedge clk); bus.en = 1'b0;
      end else begin
        tick_step();
      end
      if (k == 12) begin
        check("done_lag", 32'(bus.done), 0);
        @(negedge clk);
        check("done_rise", 32'(bus.done), 1);
      end
      model_v = model_up(model_v);
      exp_q.push_back(model_v); sb_check($sformatf("up_step%0d", k));
    end
    exp_q.push_back(16'h0012); tick_step(); sb_check("up_saturate");

    // Scan order and per-slot content while showing 0012
    sync_ok = 1'b0;
    for (int c = 0; c < 12 && !sync_ok; c++) begin
      @(negedge clk);
      if (bus.DIGIT == 4'b0111) sync_ok = 1'b1;
    end
    for (int c = 0; c < 12 && sync_ok && bus.DIGIT == 4'b0111; c++) @(negedge clk);
    check("scan_sync", 32'(sync_ok && bus.DIGIT == 4'b1110), 1);
    dig_ok = 1'b1; seg_ok = 1'b1;
    shown = 16'h0012;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      sel = 4'b0001 << (j / 4);
      dg  = shown[4*(j/4) +: 4];
      if (bus.DIGIT !== ~sel) dig_ok = 1'b0;
      if (bus.DISPLAY !== enc(dg)) seg_ok = 1'b0;
    end
    check("scan_digit_seq", 32'(dig_ok), 1);
    check("scan_display", 32'(seg_ok), 1);

    // Target of zero: done without any step
    reset_pulse();
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    check("zero_done_lag", 32'(bus.done), 0);
    @(negedge clk);
    check("zero_done", 32'(bus.done), 1);
    exp_q.push_back(16'h0000); tick_step(); sb_check("zero_no_step");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
